// File: rtl/tlc5941_pkg.sv
// Shared sizing constants for the TLC5941 receiver: channel geometry, expected
// shift lengths and the shift-counter width.
package tlc5941_pkg;

    localparam int unsigned CHANNELS   = 16;
    localparam int unsigned GS_BITS    = 12;
    localparam int unsigned DC_BITS    = 6;
    localparam int unsigned GS_COUNT   = CHANNELS * GS_BITS;
    localparam int unsigned DC_COUNT   = CHANNELS * DC_BITS;
    localparam int unsigned CNT_BITS   = 9;
    localparam int unsigned SYNC_DEPTH = 2;

    typedef enum logic {
        ModeGs = 1'b0,
        ModeDc = 1'b1
    } shift_mode_e;

endpackage

// File: rtl/tlc_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, plus one extra flop that
// turns the synchronized level into a single-cycle rising-edge pulse.
module tlc_sync_edge #(
    parameter int unsigned Depth = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [Depth-1:0] sync_q;
    logic             prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[Depth-2:0], d};
            prev_q <= sync_q[Depth-1];
        end
    end

    assign q    = sync_q[Depth-1];
    assign rise = sync_q[Depth-1] & ~prev_q;

endmodule

// File: rtl/tlc5941_receiver.sv
// TLC5941-style LED driver receiver: serial grayscale/dot-correction shift
// register, xlat-loaded latches, and a 12-bit grayscale PWM engine.
module tlc5941_receiver #(
    parameter int unsigned CHANNELS = tlc5941_pkg::CHANNELS,
    parameter int unsigned GS_BITS  = tlc5941_pkg::GS_BITS,
    parameter int unsigned DC_BITS  = tlc5941_pkg::DC_BITS
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        sclk,
    input  logic                        sin,
    input  logic                        xlat,
    input  logic                        mode,
    input  logic                        blank,
    input  logic                        gsclk,
    output logic                        sout,
    output logic [CHANNELS-1:0]         pwm_out,
    output logic [CHANNELS*DC_BITS-1:0] dc_out,
    output logic                        latched,
    output logic                        length_err
);

    import tlc5941_pkg::*;

    localparam int unsigned SrBits  = CHANNELS * GS_BITS;
    localparam int unsigned DcWidth = CHANNELS * DC_BITS;
    localparam logic [CNT_BITS-1:0] GsCount = CNT_BITS'(GS_COUNT);
    localparam logic [CNT_BITS-1:0] DcCount = CNT_BITS'(DC_COUNT);

    logic sclk_s, sin_s, xlat_s, mode_s, blank_s, gsclk_s;
    logic sclk_rise, sin_rise, xlat_rise, mode_rise, blank_rise, gsclk_rise;

    // sin and mode share the synchronizer depth of sclk/xlat, so they stay aligned.
    tlc_sync_edge #(.Depth(SYNC_DEPTH)) u_sync_sclk (
        .clock(clock), .reset(reset), .d(sclk), .q(sclk_s), .rise(sclk_rise)
    );
    tlc_sync_edge #(.Depth(SYNC_DEPTH)) u_sync_sin (
        .clock(clock), .reset(reset), .d(sin), .q(sin_s), .rise(sin_rise)
    );
    tlc_sync_edge #(.Depth(SYNC_DEPTH)) u_sync_xlat (
        .clock(clock), .reset(reset), .d(xlat), .q(xlat_s), .rise(xlat_rise)
    );
    tlc_sync_edge #(.Depth(SYNC_DEPTH)) u_sync_mode (
        .clock(clock), .reset(reset), .d(mode), .q(mode_s), .rise(mode_rise)
    );
    tlc_sync_edge #(.Depth(SYNC_DEPTH)) u_sync_blank (
        .clock(clock), .reset(reset), .d(blank), .q(blank_s), .rise(blank_rise)
    );
    tlc_sync_edge #(.Depth(SYNC_DEPTH)) u_sync_gsclk (
        .clock(clock), .reset(reset), .d(gsclk), .q(gsclk_s), .rise(gsclk_rise)
    );

    logic unused_sync;
    assign unused_sync = ^{sclk_s, xlat_s, gsclk_s, sin_rise, mode_rise, blank_rise};

    logic [SrBits-1:0]   shift_q, shift_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d, cnt_shifted;
    logic [SrBits-1:0]   gs_q, gs_d;
    logic [DcWidth-1:0]  dc_q, dc_d;
    logic [GS_BITS-1:0]  gs_cnt_q, gs_cnt_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                latched_q, latched_d;
    logic                length_err_q, length_err_d;

    // A shift in the same cycle as xlat is applied first, so the latch and the
    // length check both see the post-shift state.
    always_comb begin
        shift_d      = shift_q;
        cnt_shifted  = cnt_q;
        gs_d         = gs_q;
        dc_d         = dc_q;
        latched_d    = 1'b0;
        length_err_d = 1'b0;

        if (sclk_rise) begin
            shift_d = {shift_q[SrBits-2:0], sin_s};
            if (cnt_q != '1) begin
                cnt_shifted = cnt_q + 1'b1;
            end
        end
        cnt_d = cnt_shifted;

        if (xlat_rise) begin
            cnt_d     = '0;
            latched_d = 1'b1;
            if (shift_mode_e'(mode_s) == ModeDc) begin
                dc_d         = shift_d[DcWidth-1:0];
                length_err_d = (cnt_shifted != DcCount);
            end else begin
                gs_d         = shift_d;
                length_err_d = (cnt_shifted != GsCount);
            end
        end
    end

    always_comb begin
        gs_cnt_d = gs_cnt_q;
        if (blank_s) begin
            gs_cnt_d = '0;
        end else if (gsclk_rise && (gs_cnt_q != '1)) begin
            gs_cnt_d = gs_cnt_q + 1'b1;
        end

        pwm_d = '0;
        for (int unsigned n = 0; n < CHANNELS; n++) begin
            pwm_d[n] = !blank_s && (gs_cnt_q < gs_q[n*GS_BITS +: GS_BITS]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            gs_q         <= '0;
            dc_q         <= '1;
            gs_cnt_q     <= '0;
            pwm_q        <= '0;
            latched_q    <= 1'b0;
            length_err_q <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            gs_q         <= gs_d;
            dc_q         <= dc_d;
            gs_cnt_q     <= gs_cnt_d;
            pwm_q        <= pwm_d;
            latched_q    <= latched_d;
            length_err_q <= length_err_d;
        end
    end

    assign sout       = shift_q[SrBits-1];
    assign pwm_out    = pwm_q;
    assign dc_out     = dc_q;
    assign latched    = latched_q;
    assign length_err = length_err_q;

endmodule

// File: tb/tb_tlc5941_receiver.sv
// Randomized bench for tlc5941_receiver: three chained devices driven through a
// bit-history reference model of the shift, latch, length and PWM rules.
module tb_tlc5941_receiver;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic sclk = 1'b0, sin = 1'b0, xlat = 1'b0, mode = 1'b0, blank = 1'b0, gsclk = 1'b0;

    logic        sout0, sout1, sout2;
    logic [15:0] pwm0, pwm1, pwm2;
    logic [95:0] dc0, dc1, dc2;
    logic        lat0, lat1, lat2;
    logic        le0, le1, le2;

    always #5 clock = ~clock;

    tlc5941_receiver dut0 (
        .clock(clock), .reset(reset), .sclk(sclk), .sin(sin), .xlat(xlat), .mode(mode),
        .blank(blank), .gsclk(gsclk), .sout(sout0), .pwm_out(pwm0), .dc_out(dc0),
        .latched(lat0), .length_err(le0)
    );
    tlc5941_receiver dut1 (
        .clock(clock), .reset(reset), .sclk(sclk), .sin(sout0), .xlat(xlat), .mode(mode),
        .blank(blank), .gsclk(gsclk), .sout(sout1), .pwm_out(pwm1), .dc_out(dc1),
        .latched(lat1), .length_err(le1)
    );
    tlc5941_receiver dut2 (
        .clock(clock), .reset(reset), .sclk(sclk), .sin(sout1), .xlat(xlat), .mode(mode),
        .blank(blank), .gsclk(gsclk), .sout(sout2), .pwm_out(pwm2), .dc_out(dc2),
        .latched(lat2), .length_err(le2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: every bit shifted since reset, bits since the last xlat,
    // expected latch contents and the ideal grayscale count.
    bit           hist[$];
    int           since_xlat = 0;
    logic [191:0] exp_gs = '0;
    logic [95:0]  exp_dc = '1;
    int           gcount = 0;

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Last w shifted bits as a word; the most recent bit is bit 0.
    function automatic logic [191:0] last_bits(input int w);
        logic [191:0] v = '0;
        int n = hist.size();
        for (int i = 0; i < w; i++) begin
            int idx = n - w + i;
            v[w-1-i] = (idx >= 0) ? hist[idx] : 1'b0;
        end
        return v;
    endfunction

    function automatic logic [15:0] exp_pwm();
        logic [15:0] r = '0;
        for (int n = 0; n < 16; n++) begin
            r[n] = !blank && (gcount < int'(exp_gs[n*12 +: 12]));
        end
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; sclk = 1'b0; xlat = 1'b0; gsclk = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        hist.delete();
        since_xlat = 0;
        exp_gs = '0;
        exp_dc = '1;
        gcount = 0;
    endtask

    task automatic shift_bit(input logic b);
        @(negedge clock);
        sin = b;
        repeat (3) @(negedge clock);
        sclk = 1'b1;
        repeat (4) @(negedge clock);
        sclk = 1'b0;
        hist.push_back(b);
        since_xlat++;
    endtask

    task automatic shift_word(input logic [11:0] w, input int width);
        for (int i = width - 1; i >= 0; i--) shift_bit(w[i]);
    endtask

    task automatic shift_rand(input int n);
        for (int i = 0; i < n; i++) shift_bit(1'($urandom_range(1, 0)));
    endtask

    // Pulse xlat (optionally with a coincident sclk edge) and check the result.
    task automatic latch_and_check(input string tag, input logic m, input logic with_shift,
                                   input logic b);
        int n_lat = 0;
        int n_err = 0;
        logic err_seen = 1'b0;
        logic exp_err;
        logic [191:0] tmp;
        @(negedge clock);
        mode = m;
        if (with_shift) sin = b;
        repeat (3) @(negedge clock);
        xlat = 1'b1;
        if (with_shift) begin
            sclk = 1'b1;
            hist.push_back(b);
            since_xlat++;
        end
        exp_err = m ? (since_xlat != 96) : (since_xlat != 192);
        tmp = last_bits(m ? 96 : 192);
        if (m) exp_dc = tmp[95:0];
        else exp_gs = tmp;
        since_xlat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (lat0) begin
                n_lat++;
                err_seen = le0;
            end
            if (le0) n_err++;
            if (i == 4) begin
                xlat = 1'b0;
                sclk = 1'b0;
            end
        end
        check({tag, " latched"}, 192'(n_lat), 192'(1));
        check({tag, " err"}, 192'(err_seen), 192'(exp_err));
        check({tag, " err_pulses"}, 192'(n_err), 192'(exp_err ? 1 : 0));
        check({tag, " gs"}, dut0.gs_q, exp_gs);
        check({tag, " dc"}, 192'(dc0), 192'(exp_dc));
    endtask

    task automatic gs_edge(input int hold);
        gsclk = 1'b1;
        repeat (hold) @(negedge clock);
        gsclk = 1'b0;
        repeat (hold) @(negedge clock);
        if (blank) gcount = 0;
        else if (gcount < 4095) gcount++;
    endtask

    initial begin
        #800_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0]  words [48];
        logic [191:0] exp_chain [3];
        logic [191:0] tmp;
        int           hi;

        do_reset();
        repeat (2) @(negedge clock);
        check("rst sout", 192'(sout0), 192'(0));
        check("rst pwm", 192'(pwm0), 192'(0));
        check("rst latched", 192'(lat0), 192'(0));
        check("rst length_err", 192'(le0), 192'(0));
        check("rst dc", 192'(dc0), 192'({96{1'b1}}));
        check("rst gs", dut0.gs_q, 192'(0));

        // Channel 15 full scale, everything else zero.
        shift_word(12'hFFF, 12);
        for (int i = 0; i < 15; i++) shift_word(12'h000, 12);
        tmp = last_bits(192);
        check("sout msb", 192'(sout0), 192'(tmp[191]));
        latch_and_check("gs_ch15", 1'b0, 1'b0, 1'b0);
        check("gs15 value", 192'(dut0.gs_q[191:180]), 192'(4095));

        shift_rand(191);
        tmp = last_bits(192);
        check("sout short", 192'(sout0), 192'(tmp[191]));
        latch_and_check("short", 1'b0, 1'b0, 1'b0);

        // 192nd bit arrives in the same cycle as xlat.
        shift_rand(191);
        latch_and_check("same_edge", 1'b0, 1'b1, 1'($urandom_range(1, 0)));

        for (int i = 0; i < 16; i++) shift_word(12'h015, 6);
        latch_and_check("dc", 1'b1, 1'b0, 1'b0);
        check("dc pattern", 192'(dc0), 192'({16{6'h15}}));

        for (int r = 0; r < 4; r++) begin
            logic m = 1'($urandom_range(1, 0));
            int   n = m ? 96 : 192;
            if ($urandom_range(3, 0) == 0) n = n - 1 + 2 * int'($urandom_range(1, 0));
            shift_rand(n);
            latch_and_check("rand", m, 1'b0, 1'b0);
        end

        // Partial word discarded by reset.
        shift_rand(100);
        do_reset();
        shift_rand(192);
        latch_and_check("post_reset", 1'b0, 1'b0, 1'b0);

        // PWM: ch0=3, ch1=4095, ch2=0, rest random.
        for (int ch = 15; ch >= 0; ch--) begin
            logic [11:0] w = 12'($urandom);
            if (ch == 0) w = 12'd3;
            if (ch == 1) w = 12'hFFF;
            if (ch == 2) w = 12'd0;
            shift_word(w, 12);
        end
        latch_and_check("pwm_load", 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clock);
        check("pwm count0", 192'(pwm0), 192'(exp_pwm()));
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            if (pwm0[0]) hi++;
            gs_edge(3);
            @(negedge clock);
            check("pwm step", 192'(pwm0), 192'(exp_pwm()));
        end
        check("pwm0 periods", 192'(hi), 192'(3));
        blank = 1'b1;
        repeat (4) @(negedge clock);
        check("blank off", 192'(pwm0), 192'(0));
        gs_edge(3);
        gs_edge(3);
        check("blank hold", 192'(pwm0), 192'(0));
        blank = 1'b0;
        repeat (4) @(negedge clock);
        check("unblank", 192'(pwm0), 192'(exp_pwm()));
        for (int k = 0; k < 4094; k++) gs_edge(2);
        repeat (2) @(negedge clock);
        check("pwm 4094", 192'(pwm0), 192'(exp_pwm()));
        check("pwm1 at 4094", 192'(pwm0[1]), 192'(1));
        gs_edge(2);
        repeat (2) @(negedge clock);
        check("pwm1 at 4095", 192'(pwm0[1]), 192'(0));
        gs_edge(2);
        repeat (2) @(negedge clock);
        check("gs_cnt sat", 192'(dut0.gs_cnt_q), 192'(4095));
        check("pwm sat", 192'(pwm0), 192'(exp_pwm()));

        // Three-device chain, 576-bit frame, word 5 = 0xABC.
        for (int d = 0; d < 3; d++) exp_chain[d] = '0;
        for (int w = 0; w < 48; w++) begin
            words[w] = (w == 5) ? 12'hABC : 12'($urandom);
            exp_chain[2 - w / 16][(15 - w % 16) * 12 +: 12] = words[w];
        end
        for (int w = 0; w < 48; w++) shift_word(words[w], 12);
        latch_and_check("chain", 1'b0, 1'b0, 1'b0);
        check("chain dev0", dut0.gs_q, exp_chain[0]);
        check("chain dev1", dut1.gs_q, exp_chain[1]);
        check("chain dev2", dut2.gs_q, exp_chain[2]);
        check("chain first word", 192'(dut2.gs_q[191:180]), 192'(words[0]));
        check("chain abc", 192'(dut2.gs_q[10*12 +: 12]), 192'(12'hABC));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
